// File: rtl/fetch_sequencer_pkg.sv
// Shared widths and state encoding for the two-half instruction fetch sequencer.
// ERR exists only when FETCH_TIMEOUT_EN is defined.
package fetch_sequencer_pkg;

  localparam int DATA_BUS_WIDTH    = 16;
  localparam int ADDRESS_BUS_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_HI = 3'd1,
    REQ_LO = 3'd2,
    DONE   = 3'd3
`ifdef FETCH_TIMEOUT_EN
    ,
    ERR    = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetches one instruction as two memory words (high half at pc, low at pc+1).
// Optional per-access wait timeout is enabled with FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int DATA_BUS_WIDTH    = fetch_sequencer_pkg::DATA_BUS_WIDTH,
  parameter int ADDRESS_BUS_WIDTH = fetch_sequencer_pkg::ADDRESS_BUS_WIDTH,
  parameter int TIMEOUT_CYCLES    = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         pc_load,
  input  logic [ADDRESS_BUS_WIDTH-1:0] pc_in,
  output logic                         mem_rd,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  input  logic                         mem_ready,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata,
  output logic                         ir_en,
  output logic                         ir_hi_select,
  output logic [DATA_BUS_WIDTH-1:0]    ir_data,
  output logic [ADDRESS_BUS_WIDTH-1:0] pc,
  output logic                         busy,
  output logic                         fetch_done,
  output logic                         fetch_err
);

  import fetch_sequencer_pkg::*;

  state_t state;
  state_t next;
  logic   timeout;
  logic   in_req;

  assign in_req = (state == REQ_HI) || (state == REQ_LO);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  // Any ready or state change clears the count, so each access starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (in_req && !mem_ready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = in_req && !mem_ready &&
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (state == IDLE && pc_load) begin
      pc <= pc_in;
    end else if (state == REQ_LO && mem_ready) begin
      pc <= pc + ADDRESS_BUS_WIDTH'(2);
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (start) next = REQ_HI;
      end
      REQ_HI: begin
        if (mem_ready) next = REQ_LO;
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) next = ERR;
`endif
      end
      REQ_LO: begin
        if (mem_ready) next = DONE;
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) next = ERR;
`endif
      end
      DONE: next = IDLE;
`ifdef FETCH_TIMEOUT_EN
      ERR: next = IDLE;
`endif
      default: next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd       = 1'b0;
    mem_addr     = pc;
    ir_en        = 1'b0;
    ir_hi_select = 1'b0;
    fetch_done   = 1'b0;
    fetch_err    = 1'b0;
    unique case (1'b1)
      state == REQ_HI: begin
        mem_rd       = 1'b1;
        ir_en        = mem_ready;
        ir_hi_select = mem_ready;
      end
      state == REQ_LO: begin
        mem_rd   = 1'b1;
        mem_addr = pc + ADDRESS_BUS_WIDTH'(1);
        ir_en    = mem_ready;
      end
      state == DONE: fetch_done = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      state == ERR: fetch_err = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign ir_data = mem_rdata;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected IR loads queued as memory
// responds, popped and compared whenever the DUT pulses ir_en.
module tb_fetch_sequencer;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          ir_en;
  logic          ir_hi_select;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] pc;
  logic          busy;
  logic          fetch_done;
  logic          fetch_err;

  fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pc_load      (pc_load),
    .pc_in        (pc_in),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .ir_en        (ir_en),
    .ir_hi_select (ir_hi_select),
    .ir_data      (ir_data),
    .pc           (pc),
    .busy         (busy),
    .fetch_done   (fetch_done),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hi;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } ir_exp_t;

  ir_exp_t sb[$];
  ir_exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ir_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (fetch_done) done_cnt++;
    if (fetch_err) err_cnt++;
    if (ir_en) begin
      ir_cnt++;
      if (sb.size() == 0) begin
        check("ir_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ir_hi_sel", {31'd0, ir_hi_select}, {31'd0, mon_e.hi});
        check("ir_data", {16'd0, ir_data}, {16'd0, mon_e.data});
        check("ir_addr", {16'd0, mem_addr}, {16'd0, mon_e.addr});
      end
    end
  end

  // Caller leaves the DUT in IDLE; pc_load may already be set for this cycle.
  task automatic fetch(input logic [AW-1:0] base, input int hi_wait,
                       input int lo_wait, input logic [DW-1:0] dhi,
                       input logic [DW-1:0] dlo, input bit poke);
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    ir_exp_t e;
    int d0;
    a1 = base + AW'(1);
    a2 = base + AW'(2);
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    pc_load = 1'b0;
    for (int i = 0; i < hi_wait; i++) begin
      mem_ready = 1'b0;
      if (poke && i == 0) begin
        start = 1'b1;
        pc_load = 1'b1;
        pc_in = 16'h1234;
      end
      #1;
      check("hi_wait_rd", {31'd0, mem_rd}, 32'd1);
      check("hi_wait_addr", {16'd0, mem_addr}, {16'd0, base});
      check("hi_wait_busy", {31'd0, busy}, 32'd1);
      step();
      start = 1'b0;
      pc_load = 1'b0;
    end
    mem_ready = 1'b1;
    mem_rdata = dhi;
    e = '{hi: 1'b1, data: dhi, addr: base};
    sb.push_back(e);
    step();
    for (int i = 0; i < lo_wait; i++) begin
      mem_ready = 1'b0;
      #1;
      check("lo_wait_rd", {31'd0, mem_rd}, 32'd1);
      check("lo_wait_addr", {16'd0, mem_addr}, {16'd0, a1});
      check("lo_wait_busy", {31'd0, busy}, 32'd1);
      step();
    end
    mem_ready = 1'b1;
    mem_rdata = dlo;
    e = '{hi: 1'b0, data: dlo, addr: a1};
    sb.push_back(e);
    step();
    mem_ready = 1'b0;
    #1;
    check("done_pulse", {31'd0, fetch_done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_rd", {31'd0, mem_rd}, 32'd0);
    step();
    #1;
    check("idle_done", {31'd0, fetch_done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("pc_after", {16'd0, pc}, {16'd0, a2});
    check("done_count", done_cnt - d0, 32'd1);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int d0;
    int i0;
    int e0;
    int cyc;
    ir_exp_t e;

    rst_n = 1'b0;
    step();
    step();
    check("rst_pc", {16'd0, pc}, 32'd0);
    check("rst_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_ir_en", {31'd0, ir_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, fetch_done}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    rst_n = 1'b1;
    step();

    mem_ready = 1'b1;
    step();
    #1;
    check("idle_ready_busy", {31'd0, busy}, 32'd0);
    mem_ready = 1'b0;

    pc_load = 1'b1;
    pc_in = 16'h0010;
    step();
    pc_load = 1'b0;
    #1;
    check("pc_loaded", {16'd0, pc}, 32'h0010);
    fetch(16'h0010, 0, 0, 16'h0ABC, 16'h0034, 1'b0);

    fetch(16'h0012, 0, 3, 16'h5678, 16'h9ABC, 1'b0);

    pc_load = 1'b1;
    pc_in = 16'hFFFF;
    fetch(16'hFFFF, 1, 0, 16'h1357, 16'h2468, 1'b0);

    fetch(16'h0001, 2, 1, 16'hAAAA, 16'h5555, 1'b1);

    pc_load = 1'b1;
    pc_in = 16'h0040;
    step();
    pc_load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'h1111;
    e = '{hi: 1'b1, data: 16'h1111, addr: 16'h0040};
    sb.push_back(e);
    step();
    mem_ready = 1'b0;
    #1;
    check("lo_addr", {16'd0, mem_addr}, 32'h0041);
    d0 = done_cnt;
    i0 = ir_cnt;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_pc", {16'd0, pc}, 32'd0);
    check("arst_rd", {31'd0, mem_rd}, 32'd0);
    mem_ready = 1'b1;
    step();
    step();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    check("arst_no_done", done_cnt - d0, 32'd0);
    check("arst_no_ir", ir_cnt - i0, 32'd0);
    check("arst_pc_hold", {16'd0, pc}, 32'd0);
    check("arst_sb_empty", sb.size(), 32'd0);

    pc_load = 1'b1;
    pc_in = 16'h0200;
    step();
    pc_load = 1'b0;
    e0 = err_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cyc = 1;
    #1;
    while (!fetch_err && cyc < 40) begin
      step();
      #1;
      cyc++;
    end
    check("err_cycle", cyc, 32'd16);
    check("err_busy", {31'd0, busy}, 32'd1);
    step();
    #1;
    check("err_idle", {31'd0, busy}, 32'd0);
    check("err_pc", {16'd0, pc}, 32'h0200);
    check("err_pulses", err_cnt - e0, 32'd1);
`else
    cyc = 0;
    repeat (20) begin
      step();
      cyc++;
    end
    #1;
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_addr", {16'd0, mem_addr}, 32'h0200);
    check("no_err", err_cnt - e0, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
